// File: rtl/decode_imm_stage_if.sv
// decode_imm_stage_if: fetch-side and execute-side handshake bundle of the decode stage.
interface decode_imm_stage_if #(
  parameter int DATASIZE = 16,
  parameter int EXT9SIZE = 9
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [DATASIZE-1:0] in_instr;
  logic [DATASIZE-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          out_opcode;
  logic [2:0]          out_ra;
  logic [2:0]          out_rb;
  logic [2:0]          out_rc;
  logic [EXT9SIZE-1:0] out_imm9;
  logic [DATASIZE-1:0] out_simm;
  logic                out_is_lui;
  logic [DATASIZE-1:0] out_pc;
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_ra, out_rb, out_rc, out_imm9, out_simm, out_is_lui, out_pc
  );
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_ra, out_rb, out_rc, out_imm9, out_simm, out_is_lui, out_pc
  );
endinterface

// File: rtl/decode_imm_stage.sv
// decode_imm_stage: 2-entry skid-buffered decode stage producing register fields and immediates.
// Define DECODE_STALL_CNT_EN to add the saturating stall_cnt output.
module decode_imm_stage #(
  parameter int DATASIZE = 16,
  parameter int EXT9SIZE = 9,
  parameter int IMM7SIZE = 7
) (
  input logic clk,
  input logic rst_n,
  decode_imm_stage_if.slave bus
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t              state;
  logic                rdy;
  logic [DATASIZE-1:0] m_instr;
  logic [DATASIZE-1:0] m_pc;
  logic [DATASIZE-1:0] s_instr;
  logic [DATASIZE-1:0] s_pc;
  logic                in_xfer;
  logic                out_xfer;
  assign in_xfer        = bus.in_valid && rdy;
  assign out_xfer       = (state != EMPTY) && bus.out_ready;
  assign bus.in_ready   = rdy;
  assign bus.out_valid  = state != EMPTY;
  assign bus.out_opcode = m_instr[DATASIZE-1 -: 3];
  assign bus.out_ra     = m_instr[DATASIZE-4 -: 3];
  assign bus.out_rb     = m_instr[9:7];
  assign bus.out_rc     = m_instr[2:0];
  assign bus.out_imm9   = m_instr[EXT9SIZE-1:0];
  assign bus.out_simm   = {{(DATASIZE-IMM7SIZE){m_instr[IMM7SIZE-1]}}, m_instr[IMM7SIZE-1:0]};
  assign bus.out_is_lui = m_instr[DATASIZE-1 -: 3] == 3'b011;
  assign bus.out_pc     = m_pc;
  // in_ready is a register so fetch never sees a combinational path from out_ready.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= EMPTY;
      rdy     <= 1'b0;
      m_instr <= '0;
      m_pc    <= '0;
      s_instr <= '0;
      s_pc    <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
      rdy   <= 1'b1;
    end else
      case (state)
        EMPTY: begin
          rdy <= 1'b1;
          if (in_xfer) begin
            m_instr <= bus.in_instr;
            m_pc    <= bus.in_pc;
            state   <= ONE;
          end
        end
        ONE:
          if (in_xfer && out_xfer) begin
            m_instr <= bus.in_instr;
            m_pc    <= bus.in_pc;
          end else if (in_xfer) begin
            s_instr <= bus.in_instr;
            s_pc    <= bus.in_pc;
            state   <= FULL;
            rdy     <= 1'b0;
          end else if (out_xfer)
            state <= EMPTY;
        FULL:
          if (out_xfer) begin
            m_instr <= s_instr;
            m_pc    <= s_pc;
            state   <= ONE;
            rdy     <= 1'b1;
          end
        default: begin
          state <= EMPTY;
          rdy   <= 1'b1;
        end
      endcase
`ifdef DECODE_STALL_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n)
      stall_cnt <= '0;
    else if (bus.in_valid && !rdy && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_decode_imm_stage.sv
// tb_decode_imm_stage: randomized self-checking bench with a queue-based reference of the decode stage.
module tb_decode_imm_stage;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  decode_imm_stage_if bus ();
`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt;
  decode_imm_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt));
`else
  decode_imm_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  logic [53:0] obs;
  assign obs = {bus.out_opcode, bus.out_ra, bus.out_rb, bus.out_rc, bus.out_imm9,
                bus.out_simm, bus.out_is_lui, bus.out_pc};
  logic [31:0] q[$];
  logic        exp_rdy;
  int          exp_stall;
  function automatic logic [53:0] exp_fields(input logic [31:0] e);
    int i, p, op, simm;
    i    = int'(e[31:16]);
    p    = int'(e[15:0]);
    op   = i / 8192;
    simm = (i % 128 >= 64) ? (i % 128) - 128 : i % 128;
    return {3'(op), 3'((i / 1024) % 8), 3'((i / 128) % 8), 3'(i % 8), 9'(i % 512),
            16'(simm), op == 3, 16'(p)};
  endfunction
  task automatic tick();
    bit ix, ox;
    ix = bus.in_valid && exp_rdy;
    ox = q.size() > 0 && bus.out_ready;
    if (rst_n && bus.in_valid && !exp_rdy) exp_stall++;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_rdy   = 1'b0;
      exp_stall = 0;
    end else if (bus.flush) begin
      q.delete();
      exp_rdy = 1'b1;
    end else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back({bus.in_instr, bus.in_pc});
      exp_rdy = q.size() < 2;
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'hFFFF;
    bus.in_pc = 16'hFFFF;
    bus.out_ready = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || obs !== '0) begin
      n_fail++;
      $display("FAIL reset: valid=%b ready=%b fields=%h, expected 0 0 0", bus.out_valid, bus.in_ready, obs);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask
  task automatic test_single();
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h6ABC;
    bus.in_pc = 16'h0010;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_is_lui !== 1'b1 || bus.out_imm9 !== 9'h0BC ||
        bus.out_ra !== 3'b010 || bus.out_rb !== 3'b101 || bus.out_pc !== 16'h0010) begin
      n_fail++;
      $display("FAIL single: valid=%b lui=%b imm9=%h ra=%b rb=%b pc=%h, expected 1 1 0bc 010 101 0010",
               bus.out_valid, bus.out_is_lui, bus.out_imm9, bus.out_ra, bus.out_rb, bus.out_pc);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: valid=%b, expected 0", bus.out_valid);
    end
  endtask
  task automatic test_sign_ext();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h0040;
    tick();
    n_tests++;
    if (bus.out_simm !== 16'hFFC0) begin
      n_fail++;
      $display("FAIL simm_neg: got %h expected ffc0", bus.out_simm);
    end
    bus.in_instr = 16'h003F;
    tick();
    n_tests++;
    if (bus.out_simm !== 16'h003F) begin
      n_fail++;
      $display("FAIL simm_pos: got %h expected 003f", bus.out_simm);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask
  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h1234;
    bus.in_pc = 16'h0100;
    tick();
    bus.in_instr = 16'hE007;
    bus.in_pc = 16'h0102;
    tick();
    bus.in_instr = 16'h5555;
    bus.in_pc = 16'h0104;
    tick();
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || obs !== exp_fields({16'h1234, 16'h0100})) begin
      n_fail++;
      $display("FAIL bp_full: ready=%b valid=%b fields=%h, expected 0 1 %h",
               bus.in_ready, bus.out_valid, obs, exp_fields({16'h1234, 16'h0100}));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || obs !== exp_fields({16'hE007, 16'h0102})) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b fields=%h, expected 1 %h", bus.out_valid, obs,
               exp_fields({16'hE007, 16'h0102}));
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask
  task automatic test_streaming();
    logic [31:0] sent[$];
    int bad;
    bad = 0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_instr = 16'($urandom);
      bus.in_pc = 16'($urandom);
      sent.push_back({bus.in_instr, bus.in_pc});
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || obs !== exp_fields(sent[i])) begin
        n_fail++;
        if (bad++ < 5)
          $display("FAIL stream[%0d]: valid=%b ready=%b fields=%h, expected 1 1 %h",
                   i, bus.out_valid, bus.in_ready, obs, exp_fields(sent[i]));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: valid=%b, expected 0", bus.out_valid);
    end
  endtask
  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_instr = 16'($urandom);
      tick();
    end
    bus.flush = 1'b1;
    bus.in_instr = 16'hABCD;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: valid=%b ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_input_seen: valid=%b, expected 0", bus.out_valid);
    end
`ifdef DECODE_STALL_CNT_EN
    n_tests++;
    if (stall_cnt !== 16'(exp_stall)) begin
      n_fail++;
      $display("FAIL flush_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
`endif
  endtask
  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = $urandom_range(0, 9) < 7;
      bus.out_ready = $urandom_range(0, 9) < 6;
      bus.flush = $urandom_range(0, 19) == 0;
      bus.in_instr = 16'($urandom);
      bus.in_pc = 16'($urandom);
      tick();
      n_tests++;
      if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== exp_rdy ||
          (q.size() > 0 && obs !== exp_fields(q[0]))) begin
        n_fail++;
        if (bad++ < 5)
          $display("FAIL random[%0d]: valid=%b ready=%b fields=%h, expected %b %b %h", i,
                   bus.out_valid, bus.in_ready, obs, q.size() > 0, exp_rdy,
                   q.size() > 0 ? exp_fields(q[0]) : 54'h0);
      end
    end
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
`ifdef DECODE_STALL_CNT_EN
    n_tests++;
    if (stall_cnt !== 16'(exp_stall)) begin
      n_fail++;
      $display("FAIL random_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
`endif
  endtask
  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = 16'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || obs !== '0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b fields=%h ready=%b, expected 0 0 0", bus.out_valid, obs, bus.in_ready);
    end
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_discard: valid=%b ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
`ifdef DECODE_STALL_CNT_EN
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (stall_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d expected 5", stall_cnt);
    end
`endif
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    exp_rdy = 1'b0;
    exp_stall = 0;
    test_reset();
    test_single();
    test_sign_ext();
    test_backpressure();
    test_streaming();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
